change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
Pays out change after a vend: accepts a refund amount in nickel units and drives the coin hopper one coin at a time, dimes first, nickels for the remainder. This is the payout direction of the coin interface. The vending controller counts `io_nickel`/`io_dime` pulses in; this block emits them out to the hopper and waits for a per-coin drop acknowledge. It sits between the vending controller (request side) and the hopper actuator (coin side).

Parameters:
- AMOUNT_W, 4, width of the refund amount in nickel units (max 15 nickels = 75c).
- ACK_TIMEOUT, 15, cycles to wait in WAIT_ACK for `io_ack` before declaring a jam; must be at least 2.
- TIMER_W, 4, width of the ack timer; must satisfy 2^TIMER_W > ACK_TIMEOUT.

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, synchronous, active-high.
- io_req_valid, input, 1, refund request present.
- io_req_amount, input, AMOUNT_W, refund in nickels.
- io_req_ready, output, 1, high only in IDLE; a request is accepted when valid && ready.
- io_dime_empty, input, 1, dime tube empty; forces nickels only.
- io_nickel_empty, input, 1, nickel tube empty.
- io_nickel, output, 1, one-cycle pulse: eject one nickel.
- io_dime, output, 1, one-cycle pulse: eject one dime.
- io_ack, input, 1, hopper reports the last ejected coin dropped.
- io_done, output, 1, one-cycle pulse: refund fully paid.
- io_error, output, 1, held high in ERROR.
- io_clear, input, 1, leaves ERROR.
- io_remaining, output, AMOUNT_W, nickels still owed.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, remaining=0, pending=0, timer=0. Outputs reset to `io_req_ready`=1 and `io_nickel`=`io_dime`=`io_done`=`io_error`=0.
- Reset mid-payout: abandons the payout immediately. No further pulses are emitted, `io_remaining`=0, and the block is in IDLE on the next cycle.
- States: IDLE, ISSUE, WAIT_ACK, DONE, ERROR.
- IDLE:
  - On accept, latch `io_req_amount` into remaining.
  - amount==0 -> DONE; otherwise -> ISSUE.
- ISSUE (exactly one cycle): coin selection, checked in this order:
  - remaining>=2 and !`io_dime_empty`: `io_dime`=1, pending=2.
  - else if !`io_nickel_empty`: `io_nickel`=1, pending=1.
  - else: no pulse, -> ERROR.
  - After a pulse, -> WAIT_ACK with timer=0.
  - `io_ack` during ISSUE is ignored.
- WAIT_ACK:
  - On `io_ack`: remaining <= remaining-pending. If the result is 0 -> DONE, else -> ISSUE.
  - Otherwise timer increments each cycle. No ack with timer==ACK_TIMEOUT-1 -> ERROR.
  - An ack on that final cycle wins over the timeout.
  - Only one ack is consumed per coin.
- DONE: `io_done`=1 for one cycle, remaining=0, -> IDLE.
- ERROR:
  - `io_error`=1; `io_remaining` holds the unpaid nickels (not decremented for the unacknowledged coin).
  - `io_clear` -> IDLE with remaining=0. `io_clear` outside ERROR is ignored.
- Arithmetic: subtraction is unsigned AMOUNT_W. Underflow cannot occur because a dime is issued only when remaining>=2.
- Tube empties are sampled only in ISSUE, so a dime tube emptying mid-refund switches subsequent coins to nickels.
- `io_nickel` and `io_dime` are never high in the same cycle.
- Minimum latency:
  - accept (cycle 0) -> first pulse (cycle 1) -> ack in the earliest WAIT_ACK cycle (cycle 2) -> `io_done` (cycle 3) -> `io_req_ready` (cycle 4).
  - Each additional coin adds 2 cycles at zero ack delay.

Decomposition:
- Shared package:
  - state enum (IDLE/ISSUE/WAIT_ACK/DONE/ERROR).
  - coin value constants NICKEL_UNITS=1 and DIME_UNITS=2.
  - default ACK_TIMEOUT.
- One natural sub-module, `change_ack_timer`: TIMER_W counter with clear/enable and an expired output at ACK_TIMEOUT-1, instantiated once.

Test Plan:
1. Reset, then request amount=3, ack 1 cycle after each pulse -> `io_dime` on cycle 1, `io_nickel` on cycle 3, `io_done` on cycle 5, `io_remaining` 3->1->0.
2. amount=4 with `io_dime_empty`=1 throughout -> exactly four `io_nickel` pulses, zero `io_dime`, then `io_done`.
3. amount=5 with `io_dime_empty` rising after the first dime acks -> pulse sequence dime, nickel, nickel, nickel; `io_done` after the 4th ack.
4. amount=2 with no ack -> after ACK_TIMEOUT (15) WAIT_ACK cycles, `io_error`=1 and `io_remaining`=2. `io_clear` -> next cycle IDLE, `io_req_ready`=1. A second run with the ack on the 15th cycle -> DONE, no error.
5. amount=0 -> no coin pulses; `io_done` 1 cycle after accept; `io_req_ready` low only during DONE.
6. amount=6, reset asserted during the 2nd WAIT_ACK -> next cycle all outputs at reset values, no further pulses; an ack arriving afterwards is ignored.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states and coin values
// expressed in nickel units.
package change_dispenser_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE    = 3'd1,
      WAIT_ACK = 3'd2,
      DONE     = 3'd3,
      ERROR    = 3'd4
   } state_t;

   localparam int NICKEL_UNITS        = 1;
   localparam int DIME_UNITS          = 2;
   localparam int DEFAULT_ACK_TIMEOUT = 15;

endpackage

// File: rtl/change_ack_timer.sv
// Counts cycles spent waiting for a coin-drop acknowledge; expired is high on the
// last permitted wait cycle (count == ACK_TIMEOUT-1).
module change_ack_timer #(
   parameter int TIMER_W     = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TIMER_W'(1);
      end
   end

   assign expired = (count == TIMER_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Refund payout controller: takes an amount in nickels and ejects dimes first, then
// nickels, one coin at a time, waiting for a hopper drop acknowledge after each coin.
import change_dispenser_pkg::*;

module change_dispenser #(
   parameter int AMOUNT_W    = 4,
   parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
   parameter int TIMER_W     = 4
) (
   input  logic                clk,
   input  logic                reset,
   // Request handshake: a refund is accepted on a cycle where io_req_valid && io_req_ready.
   input  logic                io_req_valid,
   input  logic [AMOUNT_W-1:0] io_req_amount,
   output logic                io_req_ready,
   input  logic                io_dime_empty,
   input  logic                io_nickel_empty,
   output logic                io_nickel,
   output logic                io_dime,
   input  logic                io_ack,
   output logic                io_done,
   output logic                io_error,
   input  logic                io_clear,
   output logic [AMOUNT_W-1:0] io_remaining,
   output state_t              dbg_state
);

   state_t              state, state_next;
   logic [AMOUNT_W-1:0] remaining;
   logic [AMOUNT_W-1:0] pending;
   logic [AMOUNT_W-1:0] remaining_after;
   logic                take_dime, take_nickel;
   logic                timer_expired;

   change_ack_timer #(
      .TIMER_W     (TIMER_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != WAIT_ACK),
      .enable  (state == WAIT_ACK),
      .expired (timer_expired)
   );

   // Dime only when at least two nickels are owed, so the subtraction never wraps.
   assign take_dime       = (remaining >= AMOUNT_W'(DIME_UNITS)) && !io_dime_empty;
   assign take_nickel     = !take_dime && !io_nickel_empty;
   assign remaining_after = remaining - pending;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         pending   <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE:     if (io_req_valid) remaining <= io_req_amount;
            ISSUE: begin
               if (take_dime)        pending <= AMOUNT_W'(DIME_UNITS);
               else if (take_nickel) pending <= AMOUNT_W'(NICKEL_UNITS);
            end
            WAIT_ACK: if (io_ack) remaining <= remaining_after;
            DONE:     remaining <= '0;
            ERROR:    if (io_clear) remaining <= '0;
            default:  ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (io_req_valid) state_next = (io_req_amount == '0) ? DONE : ISSUE;
         ISSUE:    state_next = (take_dime || take_nickel) ? WAIT_ACK : ERROR;
         // An ack on the final wait cycle takes priority over the timeout.
         WAIT_ACK: begin
            if (io_ack)             state_next = (remaining_after == '0) ? DONE : ISSUE;
            else if (timer_expired) state_next = ERROR;
         end
         DONE:     state_next = IDLE;
         ERROR:    if (io_clear) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      io_req_ready = (state == IDLE);
      io_dime      = 1'b0;
      io_nickel    = 1'b0;
      io_done      = 1'b0;
      io_error     = 1'b0;
      case (state)
         ISSUE: begin
            io_dime   = take_dime && !reset;
            io_nickel = take_nickel && !reset;
         end
         DONE:    io_done  = !reset;
         ERROR:   io_error = 1'b1;
         default: ;
      endcase
   end

   assign io_remaining = remaining;
   assign dbg_state    = state;

endmodule
